// File: rtl/pcpu_sequencer.sv
// pcpu_sequencer
// Program sequencer for the PseudoCPU control path. It holds a loadable
// instruction memory, fetches and decodes a small control ISA (micro-op
// issue, jumps, call/return on a hardware stack, halt) and offers micro-ops
// to the datapath over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ld_en      imem write strobe (only honoured in IDLE, HALT, ERR)
//   ld_addr    imem write address
//   ld_data    imem write data {opcode[2:0], payload[UOP_W-1:0]}
//   start      begin execution at pc 0 (only honoured in IDLE, HALT, ERR)
//   zero_flag  datapath zero status, sampled when a JZ/JNZ executes
//   uop_valid  micro-op offered
//   uop_data   micro-op payload, stable while uop_valid
//   uop_ready  datapath accepts the micro-op
//   pc         current program counter
//   busy       high in FETCH, EXEC, WAIT_UOP
//   halted     HALT executed
//   error      stack fault
//   err_code   1 = overflow, 2 = underflow, 0 otherwise
module pcpu_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int UOP_W   = 8,
    parameter int STACK_D = 4,
    localparam int IW     = 3 + UOP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [IW-1:0]     ld_data,
    input  logic              start,
    input  logic              zero_flag,
    output logic              uop_valid,
    output logic [UOP_W-1:0]  uop_data,
    input  logic              uop_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int DEPTH = 2 ** ADDR_W;
    // sp counts 0..STACK_D, so it needs one more code than the stack index
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_UOP,
        S_HALT,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_UOP  = 3'd1,
        OP_JMP  = 3'd2,
        OP_JZ   = 3'd3,
        OP_JNZ  = 3'd4,
        OP_CALL = 3'd5,
        OP_RET  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    state_t            state;
    logic [IW-1:0]     imem [DEPTH];
    logic [IW-1:0]     instr;
    logic [ADDR_W-1:0] stack [STACK_D];
    logic [SP_W-1:0]   sp;

    opcode_t           opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_seq;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              stopped;
    logic              stack_full;
    logic              stack_empty;
    logic              push_en;

    assign opcode      = opcode_t'(instr[IW-1:UOP_W]);
    assign target      = instr[ADDR_W-1:0];
    // natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 wrap
    assign pc_seq      = pc + ADDR_W'(1);
    assign sp_dec      = sp - SP_W'(1);
    assign push_idx    = sp[IDX_W-1:0];
    assign pop_idx     = sp_dec[IDX_W-1:0];
    assign stopped     = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
    assign stack_full  = (sp == SP_W'(STACK_D));
    assign stack_empty = (sp == '0);
    assign push_en     = (state == S_EXEC) && (opcode == OP_CALL) && !stack_full;

    // Instruction memory: not reset. The read register follows pc every
    // cycle; pc is stable across FETCH->EXEC so EXEC sees the FETCH word.
    // A write landing on the start edge is visible to the first FETCH read.
    always_ff @(posedge clk) begin
        if (ld_en && stopped) begin
            imem[ld_addr] <= ld_data;
        end
        instr <= imem[pc];
    end

    // Return stack storage; only sp is reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[push_idx] <= pc_seq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            sp        <= '0;
            uop_valid <= 1'b0;
            uop_data  <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= '0;
                        sp       <= '0;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                    end
                end
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_NOP: pc <= pc_seq;
                        OP_UOP: begin
                            uop_data  <= instr[UOP_W-1:0];
                            uop_valid <= 1'b1;
                            state     <= S_WAIT_UOP;
                        end
                        OP_JMP: pc <= target;
                        OP_JZ:  pc <= zero_flag ? target : pc_seq;
                        OP_JNZ: pc <= zero_flag ? pc_seq : target;
                        OP_CALL: begin
                            if (stack_full) begin
                                state    <= S_ERR;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                                err_code <= 2'd1;
                            end else begin
                                sp <= sp + SP_W'(1);
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                state    <= S_ERR;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                                err_code <= 2'd2;
                            end else begin
                                sp <= sp_dec;
                                pc <= stack[pop_idx];
                            end
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: pc <= pc_seq;
                    endcase
                end
                S_WAIT_UOP: begin
                    if (uop_ready) begin
                        uop_valid <= 1'b0;
                        pc        <= pc_seq;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpu_sequencer.sv
// tb_pcpu_sequencer
// Directed self-checking bench for pcpu_sequencer: reset state, straight-line
// micro-op issue timing, back-pressure, conditional branches, nested
// call/return with stack overflow/underflow, pc wrap, loads while busy,
// asynchronous reset mid-handshake, and restart (including load+start).
module tb_pcpu_sequencer;

    localparam int ADDR_W  = 5;
    localparam int UOP_W   = 8;
    localparam int STACK_D = 4;
    localparam int IW      = 3 + UOP_W;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] UOP  = 3'd1;
    localparam logic [2:0] JMP  = 3'd2;
    localparam logic [2:0] JZ   = 3'd3;
    localparam logic [2:0] JNZ  = 3'd4;
    localparam logic [2:0] CALL = 3'd5;
    localparam logic [2:0] RET  = 3'd6;
    localparam logic [2:0] HALT = 3'd7;

    logic              clk;
    logic              rst;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [IW-1:0]     ld_data;
    logic              start;
    logic              zero_flag;
    logic              uop_valid;
    logic [UOP_W-1:0]  uop_data;
    logic              uop_ready;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [1:0]        err_code;

    int checks   = 0;
    int failures = 0;
    logic [UOP_W-1:0] issued[$];

    pcpu_sequencer #(
        .ADDR_W (ADDR_W),
        .UOP_W  (UOP_W),
        .STACK_D(STACK_D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .zero_flag(zero_flag),
        .uop_valid(uop_valid),
        .uop_data (uop_data),
        .uop_ready(uop_ready),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .error    (error),
        .err_code (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [IW-1:0] word(input logic [2:0] op, input logic [UOP_W-1:0] p);
        return {op, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [IW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Pulses start (optionally with a same-cycle load) and records every
    // handshaken micro-op until halted or error, bounded by max_cycles.
    task automatic run_program(input int max_cycles, input logic do_ld,
                               input logic [ADDR_W-1:0] a, input logic [IW-1:0] d);
        int cyc;
        issued.delete();
        start   = 1'b1;
        ld_en   = do_ld;
        ld_addr = a;
        ld_data = d;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        cyc   = 0;
        while (!(halted === 1'b1 || error === 1'b1) && cyc < max_cycles) begin
            if (uop_valid === 1'b1 && uop_ready === 1'b1) issued.push_back(uop_data);
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= max_cycles) begin
            failures++;
            $display("[TB] FAIL run_timeout: got %0d cycles, required < %0d", cyc, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; zero_flag = 1'b0; uop_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({uop_valid, uop_data, pc, busy, halted, error, err_code} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {uop_valid, uop_data, pc, busy, halted, error, err_code});
        end
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || uop_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, uop_valid);
        end
    endtask

    task automatic test_straight_line();
        logic exp_v;
        logic [UOP_W-1:0] exp_d;
        load(0, word(UOP, 8'h11));
        load(1, word(UOP, 8'h22));
        load(2, word(HALT, 8'h00));
        uop_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_busy: got %b, required 1", busy);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_v = (i == 2) || (i == 5);
            exp_d = (i == 2) ? 8'h11 : 8'h22;
            checks++;
            if (uop_valid !== exp_v) begin
                failures++;
                $display("[TB] FAIL straight_valid c%0d: got %b, required %b", i, uop_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (uop_data !== exp_d) begin
                    failures++;
                    $display("[TB] FAIL straight_data c%0d: got %h, required %h", i, uop_data, exp_d);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || pc !== 5'd2 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL straight_halt: got halted=%b pc=%0d busy=%b, required 1 2 0",
                     halted, pc, busy);
        end
    endtask

    task automatic test_back_pressure();
        uop_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (halted !== 1'b0 || pc !== 5'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_clear: got halted=%b pc=%0d busy=%b, required 0 0 1",
                     halted, pc, busy);
        end
        tick(); tick();
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (uop_valid !== 1'b1 || uop_data !== 8'h11) begin
                failures++;
                $display("[TB] FAIL bp_hold c%0d: got valid=%b data=%h, required 1 11",
                         j, uop_valid, uop_data);
            end
            if (j == 4) uop_ready = 1'b1;
            tick();
        end
        checks++;
        if (uop_valid !== 1'b0 || pc !== 5'd1) begin
            failures++;
            $display("[TB] FAIL bp_release: got valid=%b pc=%0d, required 0 1", uop_valid, pc);
        end
        tick(); tick();
        checks++;
        if (uop_valid !== 1'b1 || uop_data !== 8'h22) begin
            failures++;
            $display("[TB] FAIL bp_second: got valid=%b data=%h, required 1 22", uop_valid, uop_data);
        end
        for (int k = 0; k < 10 && halted !== 1'b1; k++) tick();
        checks++;
        if (halted !== 1'b1 || pc !== 5'd2) begin
            failures++;
            $display("[TB] FAIL bp_halt: got halted=%b pc=%0d, required 1 2", halted, pc);
        end
    endtask

    task automatic test_branch();
        load(0, word(JZ, 8'd5));
        load(1, word(UOP, 8'hAA));
        load(2, word(HALT, 8'h00));
        load(5, word(UOP, 8'hBB));
        load(6, word(HALT, 8'h00));
        uop_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            logic [UOP_W-1:0] exp_u;
            logic [ADDR_W-1:0] exp_pc;
            // t0: JZ taken, t1: JZ fall-through, t2: JNZ taken, t3: JNZ fall-through
            if (t == 2) load(0, word(JNZ, 8'd5));
            zero_flag = (t == 0) || (t == 3);
            exp_u  = (t == 0 || t == 2) ? 8'hBB : 8'hAA;
            exp_pc = (t == 0 || t == 2) ? 5'd6 : 5'd2;
            run_program(50, 1'b0, '0, '0);
            checks++;
            if (issued.size() != 1 || issued[0] !== exp_u) begin
                failures++;
                $display("[TB] FAIL branch_uops t%0d: got n=%0d first=%h, required n=1 %h",
                         t, issued.size(), (issued.size() > 0) ? issued[0] : 8'h00, exp_u);
            end
            checks++;
            if (halted !== 1'b1 || pc !== exp_pc) begin
                failures++;
                $display("[TB] FAIL branch_halt t%0d: got halted=%b pc=%0d, required 1 %0d",
                         t, halted, pc, exp_pc);
            end
        end
        zero_flag = 1'b0;
    endtask

    task automatic test_call_stack();
        logic [UOP_W-1:0] exp_seq[7] = '{8'h81, 8'hC1, 8'hE1, 8'hF0, 8'hE2, 8'hCE, 8'h8A};
        load(0,  word(CALL, 8'd8));
        load(1,  word(HALT, 8'h00));
        load(8,  word(UOP,  8'h81));
        load(9,  word(CALL, 8'd12));
        load(10, word(UOP,  8'h8A));
        load(11, word(RET,  8'h00));
        load(12, word(UOP,  8'hC1));
        load(13, word(CALL, 8'd16));
        load(14, word(UOP,  8'hCE));
        load(15, word(RET,  8'h00));
        load(16, word(UOP,  8'hE1));
        load(17, word(CALL, 8'd20));
        load(18, word(UOP,  8'hE2));
        load(19, word(RET,  8'h00));
        load(20, word(UOP,  8'hF0));
        load(21, word(RET,  8'h00));
        uop_ready = 1'b1;
        run_program(200, 1'b0, '0, '0);
        checks++;
        if (issued.size() != 7) begin
            failures++;
            $display("[TB] FAIL call_count: got %0d, required 7", issued.size());
        end
        for (int i = 0; i < 7 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL call_order[%0d]: got %h, required %h", i, issued[i], exp_seq[i]);
            end
        end
        checks++;
        if (halted !== 1'b1 || pc !== 5'd1 || error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL call_halt: got halted=%b pc=%0d error=%b, required 1 1 0",
                     halted, pc, error);
        end

        load(21, word(CALL, 8'd24));
        run_program(200, 1'b0, '0, '0);
        checks++;
        if (issued.size() != 4 || error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow: got n=%0d error=%b code=%0d busy=%b halted=%b, required 4 1 1 0 0",
                     issued.size(), error, err_code, busy, halted);
        end

        load(0, word(RET, 8'h00));
        run_program(50, 1'b0, '0, '0);
        checks++;
        if (issued.size() != 0 || error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL underflow: got n=%0d error=%b code=%0d busy=%b, required 0 1 2 0",
                     issued.size(), error, err_code, busy);
        end
    endtask

    task automatic test_wrap_and_busy_load();
        for (int a = 0; a < 32; a++) load(ADDR_W'(a), word(NOP, 8'h00));
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || err_code !== 2'd0) begin
            failures++;
            $display("[TB] FAIL err_clear: got error=%b code=%0d, required 0 0", error, err_code);
        end
        for (int i = 1; i <= 64; i++) begin
            // this write lands while busy and must be dropped
            ld_en   = (i == 10);
            ld_addr = 5'd3;
            ld_data = word(HALT, 8'h00);
            tick();
            if (i == 62) begin
                checks++;
                if (pc !== 5'd31) begin
                    failures++;
                    $display("[TB] FAIL wrap_top: got pc=%0d, required 31", pc);
                end
            end
        end
        ld_en = 1'b0;
        checks++;
        if (pc !== 5'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_zero: got pc=%0d busy=%b, required 0 1", pc, busy);
        end
        repeat (66) tick();
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1 || pc !== 5'd1) begin
            failures++;
            $display("[TB] FAIL busy_load_ignored: got halted=%b busy=%b pc=%0d, required 0 1 1",
                     halted, busy, pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({uop_valid, uop_data, pc, busy, halted, error, err_code} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_midrun: got %h, required 0",
                     {uop_valid, uop_data, pc, busy, halted, error, err_code});
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset_handshake();
        load(0, word(UOP, 8'h5A));
        load(1, word(HALT, 8'h00));
        uop_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (uop_valid !== 1'b1 || uop_data !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL hs_pending: got valid=%b data=%h, required 1 5a", uop_valid, uop_data);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({uop_valid, uop_data, pc, busy, halted, error, err_code} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got %h, required 0",
                     {uop_valid, uop_data, pc, busy, halted, error, err_code});
        end
        tick();
        rst = 1'b1;
        uop_ready = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || uop_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_wait_idle: got busy=%b valid=%b, required 0 0", busy, uop_valid);
        end
    endtask

    task automatic test_restart();
        uop_ready = 1'b1;
        run_program(50, 1'b0, '0, '0);
        checks++;
        if (issued.size() != 1 || issued[0] !== 8'h5A || halted !== 1'b1 || pc !== 5'd1) begin
            failures++;
            $display("[TB] FAIL imem_kept: got n=%0d halted=%b pc=%0d, required 1 1 1",
                     issued.size(), halted, pc);
        end
        run_program(50, 1'b1, 5'd0, word(UOP, 8'h77));
        checks++;
        if (issued.size() != 1 || issued[0] !== 8'h77 || halted !== 1'b1 || pc !== 5'd1) begin
            failures++;
            $display("[TB] FAIL load_with_start: got n=%0d first=%h halted=%b pc=%0d, required 1 77 1 1",
                     issued.size(), (issued.size() > 0) ? issued[0] : 8'h00, halted, pc);
        end
    endtask

    initial begin
        $display("[TB] pcpu_sequencer bench starting");
        test_reset();
        test_straight_line();
        test_back_pressure();
        test_branch();
        test_call_stack();
        test_wrap_and_busy_load();
        test_reset_handshake();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
